// File: rtl/request_fifo_arbiter.sv
// Round-robin arbiter that shares the request_fifo push port among NUM_REQ sources,
// with a registered push stage and credit-tracked occupancy. Optional statistics: REQ_FIFO_ARB_STATS_EN.
module request_fifo_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 640,
    parameter int DEPTH   = 32,
    parameter int CNT_W   = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]     req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         fifo_push_en,
    output logic [WIDTH-1:0]             fifo_data_in,
    input  logic                         fifo_pop_en,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic [$clog2(DEPTH):0]       occupancy,
    output logic                         pop_underflow
`ifdef REQ_FIFO_ARB_STATS_EN
    ,
    input  logic                         stat_clear,
    output logic [NUM_REQ*CNT_W-1:0]     grant_count
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam logic [OCC_W-1:0] FULL_LVL = OCC_W'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] cand;
    logic             found;
    logic             can_accept;
    logic             xfer;
    logic             pop_hit;

    // Scan from rr_ptr upward with wrap; the first valid requester wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Handshake: a requester transfers when its req_valid and req_ready are both high in the
    // same cycle; it must hold req_valid/req_data stable until then. Only the winner sees ready.
    // Ready depends only on registered occupancy, so a pop never frees a slot in the same cycle.
    always_comb begin
        can_accept = !reset && (occupancy < FULL_LVL);
        req_ready  = '0;
        if (found && can_accept) begin
            req_ready[winner] = 1'b1;
        end
        xfer    = found && can_accept;
        pop_hit = fifo_pop_en && (occupancy != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_push_en  <= 1'b0;
            fifo_data_in  <= '0;
            grant_id      <= '0;
            occupancy     <= '0;
            pop_underflow <= 1'b0;
            rr_ptr        <= '0;
        end else begin
            fifo_push_en <= xfer;
            if (xfer) begin
                fifo_data_in <= req_data[int'(winner)*WIDTH +: WIDTH];
                grant_id     <= winner;
                rr_ptr       <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
            end
            // Occupancy includes the entry held in the push register.
            if (xfer && !pop_hit) begin
                occupancy <= occupancy + 1'b1;
            end else if (!xfer && pop_hit) begin
                occupancy <= occupancy - 1'b1;
            end
            if (fifo_pop_en && (occupancy == '0)) begin
                pop_underflow <= 1'b1;
            end
        end
    end

`ifdef REQ_FIFO_ARB_STATS_EN
    logic [CNT_W-1:0] cnt [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
        always_ff @(posedge clk) begin
            if (reset || stat_clear) begin
                cnt[i] <= '0;
            end else if (xfer && (winner == IDX_W'(i)) && (cnt[i] != '1)) begin
                cnt[i] <= cnt[i] + 1'b1;
            end
        end
        assign grant_count[i*CNT_W +: CNT_W] = cnt[i];
    end
`endif

endmodule

// File: tb/tb_request_fifo_arbiter.sv
// Scoreboard bench for request_fifo_arbiter: directed boundary cases plus randomized traffic
// checked against a queue-based reference model.
module tb_request_fifo_arbiter;

    localparam int N  = 4;
    localparam int W  = 640;
    localparam int D  = 32;
    localparam int CW = 32;

    logic             clk;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             fifo_push_en;
    logic [W-1:0]     fifo_data_in;
    logic             fifo_pop_en;
    logic [1:0]       grant_id;
    logic [5:0]       occupancy;
    logic             pop_underflow;
`ifdef REQ_FIFO_ARB_STATS_EN
    logic             stat_clear;
    logic [N*CW-1:0]  grant_count;
    int               cnt_m [N];
`endif

    request_fifo_arbiter #(.NUM_REQ(N), .WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_push_en(fifo_push_en), .fifo_data_in(fifo_data_in),
        .fifo_pop_en(fifo_pop_en), .grant_id(grant_id), .occupancy(occupancy),
        .pop_underflow(pop_underflow)
`ifdef REQ_FIFO_ARB_STATS_EN
        , .stat_clear(stat_clear), .grant_count(grant_count)
`endif
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int passes = 0;
    logic [W+1:0] exp_q[$];
    int seen_ids[$];
    int rr_m = 0;
    int occ_m = 0;
    bit uf_m = 0;
    int pend_clear = -1;
    bit fixed_data = 0;
    int push_count = 0;
    bit mon_en = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [W-1:0] rand_data();
        logic [W-1:0] v;
        for (int j = 0; j < W/32; j++) v[j*32 +: 32] = $urandom;
        return v;
    endfunction

    // One clock cycle: retire the last winner's request, raise requested ones, drive pop/reset,
    // predict req_ready from the arbitration rules and advance the reference model.
    task automatic step(input logic [N-1:0] want, input bit pop, input bit rst, input bit clr = 0);
        int win;
        bit pop_eff;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        if (pend_clear >= 0) begin
            req_valid[pend_clear] = 1'b0;
            pend_clear = -1;
        end
        for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && want[i]) begin
                req_valid[i] = 1'b1;
                req_data[i*W +: W] = fixed_data ? W'(i + 'hA0) : rand_data();
            end
        end
        fifo_pop_en = pop;
        reset = rst;
`ifdef REQ_FIFO_ARB_STATS_EN
        stat_clear = clr;
`endif
        #1;
        win = -1;
        for (int k = 0; k < N; k++)
            if (win < 0 && req_valid[(rr_m + k) % N]) win = (rr_m + k) % N;
        exp_rdy = '0;
        if (win >= 0 && occ_m < D && !rst) exp_rdy[win] = 1'b1;
        check("req_ready", req_ready, exp_rdy);
        if (rst) begin
            rr_m = 0;
            occ_m = 0;
            uf_m = 0;
`ifdef REQ_FIFO_ARB_STATS_EN
            for (int i = 0; i < N; i++) cnt_m[i] = 0;
`endif
        end else begin
            pop_eff = pop && (occ_m > 0);
            if (pop && occ_m == 0) uf_m = 1;
            if (exp_rdy != 0) begin
                exp_q.push_back({2'(win), req_data[win*W +: W]});
                rr_m = (win + 1) % N;
                pend_clear = win;
                occ_m++;
`ifdef REQ_FIFO_ARB_STATS_EN
                cnt_m[win]++;
`endif
            end
            if (pop_eff) occ_m--;
`ifdef REQ_FIFO_ARB_STATS_EN
            if (clr) for (int i = 0; i < N; i++) cnt_m[i] = 0;
`endif
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 80 && (req_valid != 0 || occ_m > 0 || exp_q.size() > 0 || pend_clear >= 0); t++)
            step('0, occ_m > 0, 0);
        check("drain_done", {req_valid != 0, occ_m > 0, exp_q.size() > 0}, 0);
    endtask

    // monitor / scoreboard
    initial begin
        logic [W+1:0] e;
        wait (mon_en);
        forever begin
            @(posedge clk);
            #2;
            if (fifo_push_en) begin
                push_count++;
                seen_ids.push_back(int'(grant_id));
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL push_expected: got push grant_id=%0d expected no push", grant_id);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_id", grant_id, e[W+1:W]);
                    checks++;
                    if (fifo_data_in === e[W-1:0]) passes++;
                    else $display("FAIL fifo_data_in: got %h expected %h", fifo_data_in, e[W-1:0]);
                end
            end
            check("occupancy", occupancy, occ_m);
            check("pop_underflow", pop_underflow, uf_m);
        end
    end

    initial begin
        reset = 1'b1;
        req_valid = '0;
        req_data = '0;
        fifo_pop_en = 1'b0;
`ifdef REQ_FIFO_ARB_STATS_EN
        stat_clear = 1'b0;
`endif
        repeat (3) step('0, 0, 1);
        check("rst_push_en", fifo_push_en, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_underflow", pop_underflow, 0);
        check("rst_data", fifo_data_in[63:0], 0);
        mon_en = 1;

        // rotation with all requesters held valid
        fixed_data = 1;
        seen_ids.delete();
        for (int c = 0; c < 9; c++) step(4'b1111, occ_m > 0, 0);
        check("rot_push_count", seen_ids.size(), 8);
        for (int c = 0; c < 8 && c < seen_ids.size(); c++) check("rot_order", seen_ids[c], c % N);
        fixed_data = 0;
        drain();

        // fill to DEPTH from requester 2
        push_count = 0;
        for (int c = 0; c < D + 3; c++) step(4'b0100, 0, 0);
        check("full_occ", occupancy, D);
        check("full_ready", req_ready, 0);
        check("full_pushes", push_count, D);
        step(4'b0100, 1, 0);
        check("pop_cycle_ready", req_ready, 0);
        step(4'b0100, 0, 0);
        check("after_pop_ready", req_ready, 4'b0100);
        check("after_pop_occ", occupancy, D - 1);
        step('0, 0, 0);
        check("refill_occ", occupancy, D);
        drain();

        // transfer and pop together at occupancy 5
        push_count = 0;
        for (int c = 0; c < 5; c++) step(4'b0010, 0, 0);
        step(4'b0010, 1, 0);
        check("occ5_before", occupancy, 5);
        step('0, 0, 0);
        check("occ5_after", occupancy, 5);
        step('0, 0, 0);
        check("occ5_pushes", push_count, 6);
        drain();

        // pop from empty
        step('0, 1, 0);
        step('0, 0, 0);
        check("underflow_set", pop_underflow, 1);
        check("underflow_occ", occupancy, 0);
        repeat (3) step('0, 0, 0);
        check("underflow_sticky", pop_underflow, 1);

        // reset right after a transfer from requester 1
        step(4'b0010, 0, 0);
        step(4'b1010, 0, 1);
        check("push_before_reset", fifo_push_en, 1);
        step(4'b1010, 0, 0);
        check("post_reset_push", fifo_push_en, 0);
        check("post_reset_occ", occupancy, 0);
        check("post_reset_uf", pop_underflow, 0);
        check("post_reset_rr", req_ready, 4'b0010);
        drain();

        // randomized traffic
        for (int c = 0; c < 500; c++) begin
            step(4'($urandom_range(0, 15)),
                 occ_m > 0 && ($urandom_range(0, 99) < (c < 250 ? 30 : 70)),
                 $urandom_range(0, 199) == 0);
        end
        drain();

`ifdef REQ_FIFO_ARB_STATS_EN
        step('0, 0, 0, 1);
        for (int c = 0; c < 3; c++) step(4'b0010, 0, 0);
        repeat (2) step('0, 0, 0);
        check("stat_cnt1", grant_count[1*CW +: CW], 3);
        for (int i = 0; i < N; i++) check("stat_model", grant_count[i*CW +: CW], cnt_m[i]);
        step('0, 0, 0, 1);
        step('0, 0, 0);
        for (int i = 0; i < N; i++) check("stat_clear", grant_count[i*CW +: CW], 0);
        drain();
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
